// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch predicts next PC; execute computes the branch address, trains the table and flags mispredicts.
module branch_target_predictor #(
    parameter int WordSize = 32,
    parameter int Entries  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [WordSize-1:0] lookup_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_target,
    input  logic                resolve_valid,
    input  logic [WordSize-1:0] resolve_pc,
    input  logic                addr_mode,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] imm,
    input  logic [WordSize-1:0] rs1d,
    input  logic                resolve_pred_taken,
    input  logic [WordSize-1:0] resolve_pred_target,
    output logic [WordSize-1:0] branch_addr,
    output logic                mispredict,
    output logic [WordSize-1:0] redirect_pc
);

    localparam int IdxBits = $clog2(Entries);
    localparam int TagBits = WordSize - IdxBits - 2;
    localparam logic [WordSize-1:0] PcStep    = WordSize'(4);
    localparam logic [WordSize-1:0] AlignMask = ~WordSize'(1);

    logic                entry_valid  [Entries];
    logic [TagBits-1:0]  entry_tag    [Entries];
    logic [WordSize-1:0] entry_target [Entries];
    logic [1:0]          entry_ctr    [Entries];

    logic [IdxBits-1:0]  lookup_idx;
    logic [TagBits-1:0]  lookup_tag;
    logic                lookup_hit;
    logic                pred_taken_next;

    logic [IdxBits-1:0]  resolve_idx;
    logic [TagBits-1:0]  resolve_tag;
    logic                resolve_hit;
    logic                mispredict_next;
    logic [1:0]          ctr_cur;
    logic [1:0]          ctr_inc;
    logic [1:0]          ctr_dec;

    assign lookup_idx  = lookup_pc[IdxBits+1:2];
    assign lookup_tag  = lookup_pc[WordSize-1:IdxBits+2];
    assign resolve_idx = resolve_pc[IdxBits+1:2];
    assign resolve_tag = resolve_pc[WordSize-1:IdxBits+2];

    always_comb begin
        lookup_hit      = entry_valid[lookup_idx] && (entry_tag[lookup_idx] == lookup_tag);
        pred_taken_next = lookup_valid && lookup_hit && entry_ctr[lookup_idx][1];
        resolve_hit     = entry_valid[resolve_idx] && (entry_tag[resolve_idx] == resolve_tag);
    end

    always_comb begin
        if (addr_mode) begin
            branch_addr = (rs1d + imm) & AlignMask;
        end else begin
            branch_addr = resolve_pc + imm;
        end
    end

    always_comb begin
        mispredict_next = resolve_valid &&
                          ((branch_taken != resolve_pred_taken) ||
                           (branch_taken && (resolve_pred_target != branch_addr)));
    end

    // Saturating counter steps for the resolving entry
    always_comb begin
        ctr_cur = entry_ctr[resolve_idx];
        ctr_inc = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        ctr_dec = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Entries; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_ctr[i]    <= 2'b01;
            end
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            // Lookup reads the table as it was before this edge's training write
            pred_valid <= lookup_valid;
            pred_taken <= pred_taken_next;
            if (lookup_valid) begin
                pred_target <= pred_taken_next ? entry_target[lookup_idx] : lookup_pc + PcStep;
            end

            mispredict <= mispredict_next;
            if (resolve_valid) begin
                redirect_pc <= branch_taken ? branch_addr : resolve_pc + PcStep;
                if (resolve_hit) begin
                    if (branch_taken) begin
                        entry_ctr[resolve_idx]    <= ctr_inc;
                        entry_target[resolve_idx] <= branch_addr;
                    end else begin
                        entry_ctr[resolve_idx] <= ctr_dec;
                    end
                end else if (branch_taken) begin
                    entry_valid[resolve_idx]  <= 1'b1;
                    entry_tag[resolve_idx]    <= resolve_tag;
                    entry_target[resolve_idx] <= branch_addr;
                    entry_ctr[resolve_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus random traffic
// checked against a table model built from the predictor's rules.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        addr_mode;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic        resolve_pred_taken;
    logic [31:0] resolve_pred_target;
    logic [31:0] branch_addr;
    logic        mispredict;
    logic [31:0] redirect_pc;

    branch_target_predictor #(.WordSize(32), .Entries(16)) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .addr_mode(addr_mode),
        .branch_taken(branch_taken), .imm(imm), .rs1d(rs1d),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .branch_addr(branch_addr), .mispredict(mispredict), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference table: one slot per index, counter kept as a plain integer 0..3
    bit          m_valid [16];
    bit   [25:0] m_tag   [16];
    bit   [31:0] m_tgt   [16];
    int          m_ctr   [16];

    bit          e_pv, e_pt, e_mp;
    bit   [31:0] e_ptgt, e_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        e_pv = 0; e_pt = 0; e_mp = 0; e_ptgt = '0; e_rd = '0;
    endtask

    // One clock: drive inputs, predict outputs from the model, compare, then train the model
    task automatic step(input bit r, input bit lv, input bit [31:0] lpc,
                        input bit rv, input bit [31:0] rpc, input bit md, input bit tk,
                        input bit [31:0] im, input bit [31:0] r1,
                        input bit ppt, input bit [31:0] ppd);
        bit [31:0] ba;
        int li, ri;
        bit lhit, rhit;
        rst = r; lookup_valid = lv; lookup_pc = lpc;
        resolve_valid = rv; resolve_pc = rpc; addr_mode = md; branch_taken = tk;
        imm = im; rs1d = r1; resolve_pred_taken = ppt; resolve_pred_target = ppd;
        #1;
        ba = md ? ((r1 + im) & 32'hFFFF_FFFE) : (rpc + im);
        if (rv) check("branch_addr", branch_addr, ba);
        li = int'((lpc >> 2) % 16);
        ri = int'((rpc >> 2) % 16);
        if (r) begin
            e_pv = 0; e_pt = 0; e_mp = 0; e_ptgt = '0; e_rd = '0;
        end else begin
            lhit = m_valid[li] && (m_tag[li] == lpc[31:6]);
            e_pv = lv;
            e_pt = lv && lhit && (m_ctr[li] >= 2);
            if (lv) e_ptgt = e_pt ? m_tgt[li] : lpc + 4;
            e_mp = rv && ((tk != ppt) || (tk && (ppd != ba)));
            if (rv) e_rd = tk ? ba : rpc + 4;
        end
        @(posedge clk);
        #1;
        check("pred_valid", 32'(pred_valid), 32'(e_pv));
        check("pred_taken", 32'(pred_taken), 32'(e_pt));
        check("pred_target", pred_target, e_ptgt);
        check("mispredict", 32'(mispredict), 32'(e_mp));
        check("redirect_pc", redirect_pc, e_rd);
        if (r) begin
            model_reset();
        end else if (rv) begin
            rhit = m_valid[ri] && (m_tag[ri] == rpc[31:6]);
            if (rhit && tk) begin
                m_ctr[ri] = (m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3;
                m_tgt[ri] = ba;
            end else if (rhit) begin
                m_ctr[ri] = (m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0;
            end else if (tk) begin
                m_valid[ri] = 1;
                m_tag[ri]   = rpc[31:6];
                m_tgt[ri]   = ba;
                m_ctr[ri]   = 2;
            end
        end
    endtask

    task automatic look(input bit [31:0] pc);
        step(0, 1, pc, 0, '0, 0, 0, '0, '0, 0, '0);
    endtask

    task automatic res(input bit [31:0] pc, input bit tk, input bit [31:0] im,
                       input bit ppt, input bit [31:0] ppd);
        step(0, 0, '0, 1, pc, 0, tk, im, '0, ppt, ppd);
    endtask

    initial begin
        bit [31:0] pcs [8];
        pcs = '{32'h100, 32'h140, 32'h104, 32'h2000, 32'h180, 32'h1100, 32'h13C, 32'h0};
        model_reset();

        step(1, 0, '0, 0, '0, 0, 0, '0, '0, 0, '0);
        step(1, 1, 32'h100, 1, 32'h100, 0, 1, 32'h40, '0, 0, '0);
        check("rst_drops_lookup", pred_target, 32'h0);

        look(32'h100);
        check("s1_taken", 32'(pred_taken), 32'h0);
        check("s1_target", pred_target, 32'h104);

        res(32'h100, 1, 32'h40, 0, '0);
        check("s2_mispredict", 32'(mispredict), 32'h1);
        check("s2_redirect", redirect_pc, 32'h140);
        look(32'h100);
        check("s2_taken", 32'(pred_taken), 32'h1);
        check("s2_target", pred_target, 32'h140);

        res(32'h100, 0, 32'h40, 1, 32'h140);
        res(32'h100, 0, 32'h40, 0, 32'h0);
        look(32'h100);
        check("s3_ctr00_nt", 32'(pred_taken), 32'h0);
        res(32'h100, 0, 32'h40, 0, 32'h0);
        for (int i = 0; i < 4; i++) res(32'h100, 1, 32'h40, 0, 32'h0);
        look(32'h100);
        check("s3_sat_taken", 32'(pred_taken), 32'h1);
        res(32'h100, 0, 32'h40, 1, 32'h140);
        look(32'h100);
        check("s3_from11_taken", 32'(pred_taken), 32'h1);

        step(0, 0, '0, 1, 32'h300, 1, 1, 32'h4, 32'h2001, 1, 32'h2004);
        check("s4_branch_addr", branch_addr, 32'h2004);
        check("s4_mispredict", 32'(mispredict), 32'h0);
        check("s4_redirect", redirect_pc, 32'h2004);

        look(32'h140);
        check("s5_alias_miss", 32'(pred_taken), 32'h0);
        check("s5_alias_target", pred_target, 32'h144);
        res(32'h140, 1, 32'h10, 0, '0);
        look(32'h100);
        check("s5_replaced", 32'(pred_taken), 32'h0);

        step(0, 1, 32'h140, 1, 32'h140, 0, 0, 32'h10, '0, 1, 32'h150);
        check("s6_rbw_taken", 32'(pred_taken), 32'h1);
        check("s6_rbw_target", pred_target, 32'h150);
        look(32'h140);
        check("s6_after_update", 32'(pred_taken), 32'h0);

        res(32'h140, 1, 32'h10, 0, '0);
        step(1, 1, 32'h140, 1, 32'h140, 0, 1, 32'h10, '0, 0, '0);
        check("rst_mispredict", 32'(mispredict), 32'h0);
        check("rst_redirect", redirect_pc, 32'h0);
        look(32'h140);
        check("rst_all_miss", 32'(pred_taken), 32'h0);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom), pcs[$urandom_range(0, 7)],
                 1'($urandom), pcs[$urandom_range(0, 7)],
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15) * 4),
                 $urandom, 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? pcs[$urandom_range(0, 7)] : $urandom);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
